fifo_axi_w_drain: RTL

Read-side consumer for the write-data async FIFO in the AXI-DDR path. It accepts a burst command (AXI len) and pulls exactly len+1 words from the FIFO read port. It presents them on an AXI W-channel style valid/ready interface and asserts w_last on the final beat. A 2-entry output buffer absorbs the FIFO's 1-cycle read latency and keeps 1 beat/cycle throughput under backpressure.

---
 rtl/fifo_axi_w_drain.sv | 76 +++++++
 1 files changed

// File: rtl/fifo_axi_w_drain.sv
// fifo_axi_w_drain: pulls len+1 words from a FIFO read port and streams them as an AXI W burst
module fifo_axi_w_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic                    fifo_empty,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_last,
  output logic                    busy
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, out_cnt_q, out_cnt_d;
  logic [LEN_WIDTH:0]    rd_left_q, rd_left_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  hd_q, hd_d, inflight_q, inflight_d;
  logic [1:0]            cnt_q, cnt_d, occ;
  logic                  accept, bypass, pop, buf_pop, push;
  always_comb begin
    cmd_ready  = (state_q == IDLE) && !rd_rst;
    busy       = state_q == BURST;
    accept     = cmd_valid && cmd_ready;
    bypass     = (cnt_q == 2'd0) && inflight_q;
    w_valid    = (cnt_q != 2'd0) || inflight_q;
    w_data     = bypass ? fifo_rd_data : mem_q[hd_q];
    w_strb     = '1;
    w_last     = w_valid && (out_cnt_q == len_q);
    pop        = w_valid && w_ready;
    buf_pop    = pop && !bypass;
    push       = inflight_q && !(bypass && pop);
    occ        = cnt_q + 2'(inflight_q) - 2'(pop);
    fifo_rd_en = busy && !rd_rst && !fifo_empty && (rd_left_q != '0) && (occ < 2'd2);
    inflight_d = fifo_rd_en;
    hd_d       = hd_q ^ buf_pop;
    cnt_d      = cnt_q + 2'(push) - 2'(buf_pop);
    mem_d      = mem_q;
    if (push) mem_d[hd_q ^ cnt_q[0]] = fifo_rd_data;
    state_d    = accept ? BURST : (pop && w_last) ? IDLE : state_q;
    len_d      = accept ? cmd_len : len_q;
    rd_left_d  = accept ? {1'b0, cmd_len} + (LEN_WIDTH+1)'(1) : rd_left_q - (LEN_WIDTH+1)'(fifo_rd_en);
    out_cnt_d  = accept ? '0 : out_cnt_q + LEN_WIDTH'(pop);
  end
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      out_cnt_q  <= '0;
      rd_left_q  <= '0;
      mem_q      <= '{default: '0};
      hd_q       <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      out_cnt_q  <= out_cnt_d;
      rd_left_q  <= rd_left_d;
      mem_q      <= mem_d;
      hd_q       <= hd_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end
endmodule
